cmp_rgb_seq: RTL and testbench
==============================

// Module: cmp_rgb_seq
// PURPOSE
//   Parametrised, multi-cycle magnitude comparator with RGB LED result drive; successor to the 2-bit combinational comparator.
//   Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, with early termination on first differing digit.
//   Supports unsigned and two's-complement modes; start/busy/done handshake; registered result held until next compare.
//   Sits between switch/operand registers and board RGB LED pins.
// PARAMETERS
//   WIDTH  8  operand width in bits; >= 2
//   DIGIT  2  bits examined per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0 (else elaboration error)
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   start        in   1      request compare; accepted only when busy=0
//   signed_mode  in   1      1 = two's-complement compare; sampled with start
//   a            in   WIDTH  operand A; sampled with start
//   b            in   WIDTH  operand B; sampled with start
//   busy         out  1      compare in progress
//   done         out  1      one-cycle pulse: new result on R/G/B this cycle
//   valid        out  1      R/G/B hold a result from the most recent accepted start
//   R            out  1      a >= b
//   G            out  1      a <= b
//   B            out  1      a != b
// BEHAVIOUR
//   Reset (rst=1 at edge): busy=0, done=0, valid=0, R=G=B=0, step index=0, state IDLE. Overrides everything incl. start.
//   Reset mid-compare aborts; no done pulse; old result discarded (valid=0).
//   FSM: IDLE -> COMPARE on accepted start; COMPARE -> IDLE on decision. No separate DONE state.
//   Accept: edge with start=1 & busy=0 -> latch a,b,signed_mode; busy<=1; valid<=0; idx<=0. R/G/B keep old values.
//   start while busy=1 ignored (no queueing, no effect on operands).
//   Signed mode: invert bit WIDTH-1 of both latched operands, then unsigned compare.
//   STEPS = WIDTH/DIGIT. COMPARE cycle k (k=0..STEPS-1) examines slice [WIDTH-1-k*DIGIT -: DIGIT].
//   Decision at edge of COMPARE cycle k when slices differ OR k=STEPS-1:
//     slice_a > slice_b: R=1 G=0 B=1; slice_a < slice_b: R=0 G=1 B=1; all equal: R=1 G=1 B=0.
//     Same edge: done<=1, valid<=1, busy<=0. done drops next edge.
//   Otherwise idx<=idx+1, remain COMPARE.
//   Latency: done high N cycles after accept edge, N = 1-based index of first differing digit, or STEPS if equal.
//   Back-to-back: start may be asserted in the done cycle (busy=0); accepted there, next result N cycles later.
//   Invariant: R|G=1 whenever valid=1; R&G&B never 1; busy and done never both 1.
// TESTING (WIDTH=8, DIGIT=2 unless stated)
//   Reset: rst=1 for 2 cycles with start=1 -> busy=done=valid=R=G=B=0 throughout.
//   Equal: a=0x5A b=0x5A unsigned -> done exactly 4 cycles after accept; R=1 G=1 B=0 valid=1.
//   Early exit: a=0xC0 b=0x3F unsigned -> done 1 cycle after accept; R=1 G=0 B=1. Same in signed -> R=0 G=1 B=1.
//   Low-digit diff: a=0x12 b=0x13 -> done 4 cycles after accept; R=0 G=1 B=1. Then start held during busy with a=0xFF -> ignored, result unchanged.
//   Reset mid-op: a=0x00 b=0x01, rst=1 at cycle 2 of COMPARE -> no done; valid=0; R=G=B=0.
//   Exhaustive: WIDTH=4 DIGIT=1 and DIGIT=4, all 256 pairs x both modes, back-to-back starts -> R/G/B match reference >=,<=,!= model; latency per rule.

Source files
------------

// File: rtl/cmp_rgb_seq.sv
// Purpose: multi-cycle MSB-first magnitude comparator driving R(>=), G(<=), B(!=) LED outputs.
// Latency: done pulses N cycles after accept; N = first differing digit (1-based) or WIDTH/DIGIT if equal.
// Backpressure: start is ignored while busy; the result is held until the next accepted start.
module cmp_rgb_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic             R,
   output logic             G,
   output logic             B
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [IW-1:0]    LAST_IDX = IW'(STEPS - 1);
   // Flipping the sign bit maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("cmp_rgb_seq: illegal WIDTH/DIGIT combination");
   end

   typedef enum logic {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [IW-1:0]    idx;
   logic [DIGIT-1:0] sla;
   logic [DIGIT-1:0] slb;
   logic             accept;
   logic             decide;

   // Operands are shifted left after each step, so the current digit is always on top.
   assign sla  = opa[WIDTH-1 -: DIGIT];
   assign slb  = opb[WIDTH-1 -: DIGIT];
   assign busy = (state == COMPARE);

   // Next state: accept in IDLE, finish on the first differing digit or on the last digit.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      decide    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = COMPARE;
            end
         end
         COMPARE: begin
            if ((sla != slb) || (idx == LAST_IDX)) begin
               decide    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand latch/shift, step index and registered LED result.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         idx   <= '0;
         done  <= 1'b0;
         valid <= 1'b0;
         R     <= 1'b0;
         G     <= 1'b0;
         B     <= 1'b0;
      end else begin
         done <= decide;
         if (accept) begin
            opa   <= a ^ (signed_mode ? SIGN_FLIP : '0);
            opb   <= b ^ (signed_mode ? SIGN_FLIP : '0);
            idx   <= '0;
            valid <= 1'b0;
         end else if (decide) begin
            R     <= (sla >= slb);
            G     <= (sla <= slb);
            B     <= (sla != slb);
            valid <= 1'b1;
         end else if (state == COMPARE) begin
            opa <= opa << DIGIT;
            opb <= opb << DIGIT;
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cmp_rgb_seq.sv
module tb_cmp_rgb_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 8-bit, 2 bits per cycle
   logic       start8 = 1'b0, sm8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, valid8, r8, g8, b8o;

   // 4-bit instances, 1 and 4 bits per cycle, sharing operand inputs
   logic       st4 = 1'b0, sel = 1'b0, sm4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       start41, start44;
   logic       busy41, done41, valid41, r41, g41, b41;
   logic       busy44, done44, valid44, r44, g44, b44;
   logic       d4_done, d4_busy, d4_valid;
   logic [2:0] d4_rgb;

   int vecs = 0;
   int errs = 0;

   assign start41  = st4 & ~sel;
   assign start44  = st4 & sel;
   assign d4_done  = sel ? done44  : done41;
   assign d4_busy  = sel ? busy44  : busy41;
   assign d4_valid = sel ? valid44 : valid41;
   assign d4_rgb   = sel ? {r44, g44, b44} : {r41, g41, b41};

   cmp_rgb_seq #(.WIDTH(8), .DIGIT(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .valid(valid8), .R(r8), .G(g8), .B(b8o)
   );

   cmp_rgb_seq #(.WIDTH(4), .DIGIT(1)) u_dut41 (
      .clk(clk), .rst(rst), .start(start41), .signed_mode(sm4), .a(a4), .b(b4),
      .busy(busy41), .done(done41), .valid(valid41), .R(r41), .G(g41), .B(b41)
   );

   cmp_rgb_seq #(.WIDTH(4), .DIGIT(4)) u_dut44 (
      .clk(clk), .rst(rst), .start(start44), .signed_mode(sm4), .a(a4), .b(b4),
      .busy(busy44), .done(done44), .valid(valid44), .R(r44), .G(g44), .B(b44)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One 8-bit compare from idle; prev_rgb is the result expected to persist until done.
   task automatic cmp8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, input int exp_lat, input logic [2:0] exp_rgb,
                       input logic [2:0] prev_rgb);
      int n;
      @(negedge clk);
      a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      chk({tag, "_busy"}, busy8, 1);
      chk({tag, "_valid_clr"}, valid8, 0);
      chk({tag, "_rgb_held"}, {r8, g8, b8o}, prev_rgb);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done8 && n < 16);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_rgb"}, {r8, g8, b8o}, exp_rgb);
      chk({tag, "_valid"}, valid8, 1);
      chk({tag, "_busy_end"}, busy8, 0);
   endtask

   // All pairs in both modes, each start issued in the previous done cycle.
   task automatic exh(input logic s);
      int digit, steps, n, exp_lat, ai, bi, x, m, av, bv;
      logic found;
      logic [2:0] exp_rgb;
      sel   = s;
      digit = s ? 4 : 1;
      steps = 4 / digit;
      @(negedge clk);
      a4 = 4'd0; b4 = 4'd0; sm4 = 1'b0; st4 = 1'b1;
      for (int v = 0; v < 512; v++) begin
         m  = v >> 8;
         av = (v >> 4) & 15;
         bv = v & 15;
         ai = (m != 0 && av >= 8) ? av - 16 : av;
         bi = (m != 0 && bv >= 8) ? bv - 16 : bv;
         exp_rgb = {ai >= bi, ai <= bi, ai != bi};
         x = av ^ bv;
         exp_lat = steps;
         found = 1'b0;
         for (int k = 0; k < steps; k++) begin
            if (!found && (((x >> (4 - (k + 1) * digit)) & ((1 << digit) - 1)) != 0)) begin
               exp_lat = k + 1;
               found = 1'b1;
            end
         end
         @(posedge clk);
         @(negedge clk);
         st4 = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!d4_done && n < 8);
         if (n != exp_lat || d4_rgb != exp_rgb || !d4_valid || d4_busy)
            $display("  at a=%0d b=%0d signed=%0d digit=%0d", av, bv, m, digit);
         chk("exh_lat", n, exp_lat);
         chk("exh_rgb", d4_rgb, exp_rgb);
         chk("exh_valid", d4_valid, 1);
         chk("exh_busy", d4_busy, 0);
         if (v < 511) begin
            a4 = 4'((v + 1) >> 4); b4 = 4'(v + 1); sm4 = ((v + 1) >> 8) != 0; st4 = 1'b1;
         end
      end
   endtask

   initial begin
      int n;
      // Reset held with start asserted must win.
      rst = 1'b1; start8 = 1'b1; a8 = 8'h5A; b8 = 8'h11; st4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_busy", busy8, 0);
         chk("rst_done", done8, 0);
         chk("rst_valid", valid8, 0);
         chk("rst_rgb", {r8, g8, b8o}, 0);
      end
      rst = 1'b0; start8 = 1'b0; st4 = 1'b0;

      cmp8("equal",       8'h5A, 8'h5A, 1'b0, 4, 3'b110, 3'b000);
      cmp8("early_u",     8'hC0, 8'h3F, 1'b0, 1, 3'b101, 3'b110);
      cmp8("early_s",     8'hC0, 8'h3F, 1'b1, 1, 3'b011, 3'b101);
      cmp8("low_digit",   8'h12, 8'h13, 1'b0, 4, 3'b010 | 3'b001, 3'b011);
      cmp8("gt_unsigned", 8'h80, 8'h7F, 1'b0, 1, 3'b101, 3'b011);

      // start held during busy with a new operand must not disturb the compare.
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h13; sm8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a8 = 8'hFF;
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("hold_busy", busy8, 1);
      start8 = 1'b0;
      n = 3;
      do begin
         @(negedge clk);
         n++;
      end while (!done8 && n < 16);
      chk("hold_lat", n, 4);
      chk("hold_rgb", {r8, g8, b8o}, 3'b011);
      @(negedge clk);
      chk("hold_no_restart", busy8, 0);
      chk("hold_done_drop", done8, 0);

      // Reset in the second compare cycle aborts with no done.
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_valid", valid8, 0);
      chk("abort_rgb", {r8, g8, b8o}, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_done", done8, 0);
      end

      exh(1'b0);
      @(negedge clk);
      exh(1'b1);
      @(negedge clk);
      st4 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
